// File: rtl/sub4_pkg.sv
// Shared types and constants for the bit-serial 4-bit subtractor.
package sub4_pkg;

    // Operand width; the datapath is built for exactly this value.
    localparam int SUB4_W = 4;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operands may be loaded and a new subtraction started only outside RUN.
    function automatic logic accepts_cmd(input state_t s);
        return (s != RUN);
    endfunction

endpackage

// File: rtl/fulladder.sv
// One-bit full adder used as the per-bit subtract cell.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial subtractor: diff = M - N (mod 2^W), one bit per clock, LSB first.
// M - N is computed as M + ~N + 1; the +1 enters as the initial carry.
// Buttons are plain levels sampled on every rising edge, with no handshake:
// btn[0] loads M, btn[1] loads N and btn[2] starts. All three are honoured
// only in IDLE or DONE. state_dbg mirrors the controller state.
module serial_sub4
    import sub4_pkg::*;
#(
    parameter int W = SUB4_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sw,
    input  logic [2:0]   btn,
    output logic [W-1:0] diff,
    output logic         borrow,
    output logic         zero,
    output logic         busy,
    output logic         done,
    output state_t       state_dbg
);

    localparam int            IW   = $clog2(W);
    localparam logic [IW-1:0] LAST = IW'(W - 1);

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   m;
    logic [W-1:0]   n;
    logic [IW-1:0]  idx;
    logic           carry;
    logic           fa_sum;
    logic           fa_cout;
    logic [W-1:0]   diff_next;

    // Single shared cell: the bit of M and the inverted bit of N at the current index.
    fulladder u_fa (
        .a    (m[idx]),
        .b    (~n[idx]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // The difference with the current bit filled in; bits above idx stay 0.
    always_comb begin
        diff_next      = diff;
        diff_next[idx] = fa_sum;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start leaves IDLE/DONE, and the last bit ends RUN.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: if (btn[2]) state_next = RUN;
            RUN:        if (idx == LAST) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy      = (state == RUN);
        done      = (state == DONE);
        state_dbg = state;
    end

    // Operand registers and the serial datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            m      <= '0;
            n      <= '0;
            diff   <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
            zero   <= 1'b0;
        end else if (accepts_cmd(state)) begin
            // Loads and start may coincide; RUN reads the freshly loaded values.
            if (btn[0]) m <= sw;
            if (btn[1]) n <= sw;
            if (btn[2]) begin
                idx    <= '0;
                carry  <= 1'b1;
                diff   <= '0;
                borrow <= 1'b0;
                zero   <= 1'b0;
            end
        end else begin
            diff  <= diff_next;
            carry <= fa_cout;
            idx   <= idx + 1'b1;
            if (idx == LAST) begin
                // No carry out of the top bit means M < N.
                borrow <= ~fa_cout;
                zero   <= (diff_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_sub4.sv
// Bench for serial_sub4: directed scenarios, an exhaustive operand sweep and
// randomized operands, checked against an arithmetic reference model.
module tb_serial_sub4;
    import sub4_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic [2:0] btn;
    logic [3:0] diff;
    logic       borrow;
    logic       zero;
    logic       busy;
    logic       done;
    state_t     state_dbg;

    int checks = 0;
    int errors = 0;

    // Reference model: operand registers as the spec defines them.
    logic [3:0] m_mod;
    logic [3:0] n_mod;
    logic [3:0] last_d;
    logic       last_b;
    logic       last_z;
    logic [3:0] exp_q[$];

    serial_sub4 #(.W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .btn       (btn),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of buttons, then sample 1 time unit after the edge.
    task automatic tick(input logic [2:0] b, input logic [3:0] s);
        btn = b;
        sw  = s;
        @(posedge clk);
        #1;
        btn = '0;
    endtask

    // Load from IDLE/DONE without starting; updates the model.
    task automatic load(input logic [2:0] b, input logic [3:0] s);
        if (b[0]) m_mod = s;
        if (b[1]) n_mod = s;
        tick(b, s);
    endtask

    // Start (with optional same-edge loads), follow RUN bit by bit, check result.
    // noise: 0 quiet, 1 btn[1]+btn[2] with sw=F on the first RUN cycle, 2 random buttons.
    task automatic run_sub(input logic [2:0] sb, input logic [3:0] ss, input int noise);
        logic [3:0] expd;
        logic [3:0] mask;
        logic [2:0] nb;
        logic [3:0] got;
        if (sb[0]) m_mod = ss;
        if (sb[1]) n_mod = ss;
        exp_q.push_back(m_mod - n_mod);
        tick(sb | 3'b100, ss);
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_diff", diff, 0);
        chk("start_borrow", borrow, 0);
        chk("start_zero", zero, 0);
        for (int j = 1; j <= 4; j++) begin
            nb = 3'b000;
            if (noise == 1 && j == 1) nb = 3'b110;
            if (noise == 2) nb = 3'($urandom_range(0, 7));
            tick(nb, (noise == 1) ? 4'hF : 4'($urandom));
            if (j < 4) begin
                mask = 4'((1 << j) - 1);
                chk("run_busy", busy, 1);
                chk("run_done", done, 0);
                chk("run_partial", diff, (m_mod - n_mod) & mask);
            end
        end
        chk("end_busy", busy, 0);
        chk("end_done", done, 1);
        chk("end_state", state_dbg, DONE);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            expd = exp_q.pop_front();
            got  = diff;
            chk("end_diff", got, expd);
            chk("end_borrow", borrow, (m_mod < n_mod) ? 1 : 0);
            chk("end_zero", zero, (expd == 4'd0) ? 1 : 0);
            last_d = expd;
            last_b = (m_mod < n_mod);
            last_z = (expd == 4'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_diff"}, diff, 0);
        chk({tag, "_borrow"}, borrow, 0);
        chk({tag, "_zero"}, zero, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_state"}, state_dbg, IDLE);
    endtask

    // Directed steps followed by sweep and random runs.
    initial begin
        rst   = 1'b1;
        btn   = '0;
        sw    = '0;
        m_mod = '0;
        n_mod = '0;
        last_d = '0;
        last_b = 1'b0;
        last_z = 1'b0;

        // Reset with buttons held: reset wins.
        tick(3'b111, 4'h9);
        tick(3'b111, 4'h9);
        check_all_zero("reset");
        rst = 1'b0;

        // 9 - 3
        load(3'b001, 4'd9);
        load(3'b010, 4'd3);
        run_sub(3'b000, 4'd0, 0);

        // Outputs hold in DONE, including across an operand load.
        load(3'b001, 4'd9);
        for (int i = 0; i < 3; i++) begin
            tick(3'b000, 4'd0);
            chk("hold_diff", diff, last_d);
            chk("hold_borrow", borrow, last_b);
            chk("hold_zero", zero, last_z);
            chk("hold_done", done, 1);
        end

        // 3 - 9
        load(3'b001, 4'd3);
        load(3'b010, 4'd9);
        run_sub(3'b000, 4'd0, 0);

        // 5 - 5, then load M=7 together with start from DONE.
        load(3'b001, 4'd5);
        load(3'b010, 4'd5);
        run_sub(3'b000, 4'd0, 0);
        run_sub(3'b001, 4'd7, 0);

        // 9 - 3 with load-N and start pressed during RUN; then rerun to show N held.
        load(3'b001, 4'd9);
        load(3'b010, 4'd3);
        run_sub(3'b000, 4'd0, 1);
        run_sub(3'b000, 4'd0, 0);

        // Reset two cycles into RUN.
        load(3'b001, 4'd9);
        load(3'b010, 4'd3);
        tick(3'b100, 4'd0);
        tick(3'b000, 4'd0);
        tick(3'b000, 4'd0);
        rst = 1'b1;
        tick(3'b000, 4'd0);
        rst = 1'b0;
        m_mod = '0;
        n_mod = '0;
        exp_q.delete();
        check_all_zero("midrun_reset");
        run_sub(3'b000, 4'd0, 0);

        // 0 - 1
        load(3'b001, 4'd0);
        load(3'b010, 4'd1);
        run_sub(3'b000, 4'd0, 0);

        // Both loads with one sw value.
        load(3'b011, 4'hC);
        run_sub(3'b000, 4'd0, 0);

        // Exhaustive operand sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                load(3'b001, 4'(a));
                load(3'b010, 4'(b));
                run_sub(3'b000, 4'd0, 0);
            end
        end

        // Random operands, random same-edge loads and random button noise in RUN.
        for (int i = 0; i < 40; i++) begin
            load(3'($urandom_range(0, 3)), 4'($urandom));
            run_sub(3'($urandom_range(0, 3)), 4'($urandom), 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
